// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants, types and address helpers for the 64-point FFT
package fft_pkg;

  localparam int N_POINTS = 64;
  localparam int LOG2N    = 6;
  localparam int N_BFLY   = N_POINTS / 2;

  typedef logic [LOG2N-1:0] addr_t;
  typedef logic [LOG2N-2:0] tw_addr_t;
  typedef logic [2:0]       stage_t;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} seq_state_t;

  typedef struct packed {
    logic  valid;
    addr_t addr_a;
    addr_t addr_b;
    logic  bank;
  } dly_entry_t;

  function automatic addr_t rol6(input addr_t x, input stage_t s);
    logic [2*LOG2N-1:0] d;
    d = {x, x} << s;
    return d[2*LOG2N-1:LOG2N];
  endfunction

endpackage

// File: rtl/fft_sequencer_if.sv
// rtl/fft_sequencer_if.sv - sequencer to capture/readout and butterfly datapath signals
interface fft_sequencer_if;
  import fft_pkg::*;

  logic     start;
  logic     busy;
  logic     done;
  logic     read_bank;
  addr_t    read_addr_a;
  addr_t    read_addr_b;
  tw_addr_t twiddle_addr;
  logic     write_en;
  addr_t    write_addr_a;
  addr_t    write_addr_b;
  logic     write_bank;
  logic     result_bank;

  modport master (
    input  start,
    output busy, done, read_bank, read_addr_a, read_addr_b, twiddle_addr,
           write_en, write_addr_a, write_addr_b, write_bank, result_bank
  );

  modport slave (
    output start,
    input  busy, done, read_bank, read_addr_a, read_addr_b, twiddle_addr,
           write_en, write_addr_a, write_addr_b, write_bank, result_bank
  );

endinterface

// File: rtl/fft_addr_delay.sv
// rtl/fft_addr_delay.sv - fixed-depth delay line aligning write control with pipeline results
module fft_addr_delay
  import fft_pkg::*;
#(
  parameter int DEPTH = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  dly_entry_t din,
  output dly_entry_t dout
);

  dly_entry_t pipe [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/fft_sequencer.sv
// rtl/fft_sequencer.sv - steps 6 stages x 32 butterflies of the in-place radix-2 DIT FFT
module fft_sequencer
  import fft_pkg::*;
#(
  parameter int RD_LATENCY   = 1,
  parameter int BFLY_LATENCY = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  fft_sequencer_if.master bus
);

  localparam int PIPE_DEPTH = RD_LATENCY + BFLY_LATENCY;
  localparam int CNT_W      = $clog2(PIPE_DEPTH + 1) + 1;
  localparam logic [CNT_W-1:0] LAST_WR  = CNT_W'(PIPE_DEPTH - 1);
  localparam logic [CNT_W-1:0] DONE_CNT = CNT_W'(PIPE_DEPTH);
  localparam stage_t   LAST_STAGE = stage_t'(LOG2N - 1);
  localparam tw_addr_t LAST_BFLY  = tw_addr_t'(N_BFLY - 1);

  seq_state_t       state, state_nxt;
  stage_t           stage;
  tw_addr_t         bfly;
  logic             read_bank;
  logic [CNT_W-1:0] drain_cnt;
  logic             issue;
  addr_t            rd_a, rd_b;
  tw_addr_t         tw;
  dly_entry_t       dly_in, dly_out;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // The last stage lingers one extra DRAIN cycle to present done outside IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.start) state_nxt = ISSUE;
      ISSUE: if (bfly == LAST_BFLY) state_nxt = DRAIN;
      DRAIN: begin
        if (stage == LAST_STAGE) begin
          if (drain_cnt == DONE_CNT) state_nxt = IDLE;
        end else if (drain_cnt == LAST_WR) begin
          state_nxt = ISSUE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage     <= '0;
      bfly      <= '0;
      read_bank <= 1'b0;
      drain_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          stage     <= '0;
          bfly      <= '0;
          read_bank <= 1'b0;
        end
        ISSUE: begin
          bfly      <= bfly + 1'b1;
          drain_cnt <= '0;
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
          if (stage != LAST_STAGE && drain_cnt == LAST_WR) begin
            stage     <= stage + 1'b1;
            read_bank <= ~read_bank;
          end
        end
        default: ;
      endcase
    end
  end

  // Twiddle index is the top 'stage' bits of bfly, i.e. the bits rotated below the pair bit.
  always_comb begin
    issue = (state == ISSUE);
    rd_a  = '0;
    rd_b  = '0;
    tw    = '0;
    if (issue) begin
      rd_a = rol6({bfly, 1'b0}, stage);
      rd_b = rol6({bfly, 1'b1}, stage);
      tw   = (LAST_BFLY << (LAST_STAGE - stage)) & bfly;
    end
    dly_in.valid  = issue;
    dly_in.addr_a = rd_a;
    dly_in.addr_b = rd_b;
    dly_in.bank   = issue & ~read_bank;

    bus.busy         = (state != IDLE);
    bus.done         = (state == DRAIN) && (stage == LAST_STAGE) && (drain_cnt == DONE_CNT);
    bus.read_bank    = read_bank;
    bus.read_addr_a  = rd_a;
    bus.read_addr_b  = rd_b;
    bus.twiddle_addr = tw;
    bus.write_en     = dly_out.valid;
    bus.write_addr_a = dly_out.addr_a;
    bus.write_addr_b = dly_out.addr_b;
    bus.write_bank   = dly_out.bank;
    bus.result_bank  = 1'(LOG2N % 2);
  end

  fft_addr_delay #(
    .DEPTH (PIPE_DEPTH)
  ) u_wr_delay (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (dly_in),
    .dout    (dly_out)
  );

endmodule

// File: tb/tb_fft_sequencer.sv
// tb/tb_fft_sequencer.sv - two sequencers (pipe depth 5 and 1) against a timing model
module tb_fft_sequencer;

  logic clk;
  logic reset_n;
  logic start;

  int total = 0;
  int bad   = 0;

  int          m_t    [2] = '{0, 0};
  int          rb_hold[2] = '{0, 0};
  int          wr_cnt [2] = '{0, 0};
  logic [63:0] wmask  [2][6];
  int          rb_seq [6] = '{0, 1, 0, 1, 0, 1};

  fft_sequencer_if ifa ();
  fft_sequencer_if ifb ();

  assign ifa.start = start;
  assign ifb.start = start;

  fft_sequencer #(.RD_LATENCY(1), .BFLY_LATENCY(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(ifa)
  );
  fft_sequencer #(.RD_LATENCY(1), .BFLY_LATENCY(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int k, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %0d expected %0d at %0t", name, k, act, exp, $time);
    end
  endtask

  function automatic int rol(input int x, input int s);
    return ((x << s) | (x >> (6 - s))) & 63;
  endfunction

  function automatic int twm(input int b, input int s);
    return (b >> (5 - s)) << (5 - s);
  endfunction

  task automatic clear_run(input int k);
    wr_cnt[k] = 0;
    for (int i = 0; i < 6; i++) wmask[k][i] = '0;
  endtask

  // t = cycles since start was accepted (0 = idle); everything follows from t and pipe depth p.
  task automatic chk(input int k, input int p, input logic rst, input logic st,
                     input logic busy, input logic done, input logic rbank,
                     input logic [5:0] ra, input logic [5:0] rb, input logic [4:0] tw,
                     input logic we, input logic [5:0] wa, input logic [5:0] wb,
                     input logic wbank, input logic resb);
    int per, d, t, s, b, u, ws, wbf, idx, nt;
    bit iss, wr;
    per = 32 + p;
    d   = 1 + 6 * per;
    if (!rst) begin
      m_t[k] = 0;
      rb_hold[k] = 0;
      clear_run(k);
    end
    t   = m_t[k];
    iss = (t >= 1) && (t <= 6 * per) && ((t - 1) % per < 32);
    s   = (t - 1) / per;
    b   = (t - 1) % per;
    u   = t - p;
    wr  = (u >= 1) && (u <= 6 * per) && ((u - 1) % per < 32);
    ws  = (u - 1) / per;
    wbf = (u - 1) % per;
    if (t >= 1) rb_hold[k] = ((s > 5) ? 5 : s) % 2;

    check("busy",        k, int'(busy),  (t >= 1) ? 1 : 0);
    check("done",        k, int'(done),  (t == d) ? 1 : 0);
    check("read_bank",   k, int'(rbank), rb_hold[k]);
    check("read_addr_a", k, int'(ra),    iss ? rol(2 * b, s) : 0);
    check("read_addr_b", k, int'(rb),    iss ? rol(2 * b + 1, s) : 0);
    check("twiddle",     k, int'(tw),    iss ? twm(b, s) : 0);
    check("write_en",    k, int'(we),    wr ? 1 : 0);
    check("write_addr_a", k, int'(wa),   wr ? rol(2 * wbf, ws) : 0);
    check("write_addr_b", k, int'(wb),   wr ? rol(2 * wbf + 1, ws) : 0);
    if (wr) check("write_bank", k, int'(wbank), (ws % 2 == 0) ? 1 : 0);
    check("result_bank", k, int'(resb), 0);

    if (t == 1) begin
      check("c1_busy", k, int'(busy), 1);
      check("c1_ra",   k, int'(ra), 0);
      check("c1_rb",   k, int'(rb), 1);
      check("c1_tw",   k, int'(tw), 0);
      check("c1_bank", k, int'(rbank), 0);
    end
    if (t == 1 + p) begin
      check("first_we", k, int'(we), 1);
      check("first_wa", k, int'(wa), 0);
      check("first_wb", k, int'(wb), 1);
    end
    if (k == 0 && iss && s == 1 && b == 1) begin
      check("spot11_a", k, int'(ra), 4);
      check("spot11_b", k, int'(rb), 6);
      check("spot11_tw", k, int'(tw), 0);
    end
    if (k == 0 && iss && s == 5 && b == 3) begin
      check("spot53_a", k, int'(ra), 3);
      check("spot53_b", k, int'(rb), 35);
      check("spot53_tw", k, int'(tw), 3);
    end
    if (k == 0 && iss && s == 2 && b == 5) begin
      check("spot25_a", k, int'(ra), 40);
      check("spot25_b", k, int'(rb), 44);
      check("spot25_tw", k, int'(tw), 0);
    end
    if (iss && b == 0) begin
      check("barrier_writes", k, wr_cnt[k], 32 * s);
      check("bank_seq",       k, int'(rbank), rb_seq[s]);
    end

    if (rst && we) begin
      idx = wr_cnt[k] / 32;
      if (idx < 6) begin
        wmask[k][idx][wa] = 1'b1;
        wmask[k][idx][wb] = 1'b1;
      end
      wr_cnt[k]++;
    end
    if (rst && done) begin
      check("done_cycle", k, t, (k == 0) ? 223 : 199);
      check("write_total", k, wr_cnt[k], 192);
      for (int i = 0; i < 6; i++)
        check("stage_cover", k, (wmask[k][i] == {64{1'b1}}) ? 1 : 0, 1);
    end

    if (!rst)        nt = 0;
    else if (t == 0) nt = st ? 1 : 0;
    else if (t == d) nt = 0;
    else             nt = t + 1;
    if (rst && t == 0 && st) clear_run(k);
    m_t[k] = nt;
  endtask

  always @(negedge clk) begin
    chk(0, 5, reset_n, ifa.start, ifa.busy, ifa.done, ifa.read_bank, ifa.read_addr_a,
        ifa.read_addr_b, ifa.twiddle_addr, ifa.write_en, ifa.write_addr_a, ifa.write_addr_b,
        ifa.write_bank, ifa.result_bank);
    chk(1, 1, reset_n, ifb.start, ifb.busy, ifb.done, ifb.read_bank, ifb.read_addr_a,
        ifb.read_addr_b, ifb.twiddle_addr, ifb.write_en, ifb.write_addr_a, ifb.write_addr_b,
        ifb.write_bank, ifb.result_bank);
  end

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (ifa.done) ok = 1'b1;
    end
  endtask

  task automatic rst_vals(input int k, input logic busy, input logic done, input logic we,
                          input logic rbank, input logic [5:0] ra, input logic [5:0] wa);
    check("rst_busy", k, int'(busy), 0);
    check("rst_done", k, int'(done), 0);
    check("rst_we",   k, int'(we), 0);
    check("rst_bank", k, int'(rbank), 0);
    check("rst_ra",   k, int'(ra), 0);
    check("rst_wa",   k, int'(wa), 0);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  initial begin
    bit ok;
    reset_n = 1'b0;
    start   = 1'b0;
    #1;
    rst_vals(0, ifa.busy, ifa.done, ifa.write_en, ifa.read_bank, ifa.read_addr_a, ifa.write_addr_a);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    pulse_start();
    wait_done(ok);
    check("wait_done_1", 0, int'(ok), 1);
    @(negedge clk);
    check("busy_after_done", 0, int'(ifa.busy), 0);

    // start held high across done: only re-accepted from IDLE
    @(posedge clk); #1 start = 1'b1;
    wait_done(ok);
    check("wait_done_2", 0, int'(ok), 1);
    @(negedge clk);
    check("idle_gap_busy", 0, int'(ifa.busy), 0);
    @(negedge clk);
    check("restart_busy", 0, int'(ifa.busy), 1);
    wait_done(ok);
    check("wait_done_3", 0, int'(ok), 1);
    @(posedge clk); #1 start = 1'b0;
    repeat (250) @(posedge clk);

    pulse_start();
    repeat (120) @(posedge clk);
    #2;
    check("pre_rst_busy", 0, int'(ifa.busy), 1);
    reset_n = 1'b0;
    #1;
    rst_vals(0, ifa.busy, ifa.done, ifa.write_en, ifa.read_bank, ifa.read_addr_a, ifa.write_addr_a);
    rst_vals(1, ifb.busy, ifb.done, ifb.write_en, ifb.read_bank, ifb.read_addr_a, ifb.write_addr_a);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clk);

    pulse_start();
    wait_done(ok);
    check("wait_done_4", 0, int'(ok), 1);
    repeat (5) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
